// File: rtl/finish_flag_goal_detector.sv
// finish_flag_goal_detector
//   Counts player/flag overlap pixels per video frame and ORs the flag edges
//   touched by those pixels. Once a frame's overlap reaches MIN_OVERLAP_PIXELS
//   for CONFIRM_FRAMES consecutive frames, the goal is reached: goalReached
//   rises and levelComplete pulses for one cycle.
//
// Ports:
//   clk                  pixel clock
//   resetN               asynchronous active-low reset
//   startOfFrame         one-cycle pulse on the first pixel of a frame
//   enable               level running; low returns to IDLE and clears all
//   playerDrawingRequest player pixel opaque
//   flagDrawingRequest   flag pixel opaque
//   flagHitEdgeCode      {Left, Top, Right, Bottom} edge code of the flag pixel
//   levelComplete        one-cycle pulse when the goal is reached
//   goalReached          high while the goal is held
//   overlapPixelCount    overlap pixel count of the last completed frame
//   hitEdgeLatched       OR of edge codes over the last completed frame
//   frameHitCount        current consecutive hit-frame count
module finish_flag_goal_detector #(
  parameter int unsigned MIN_OVERLAP_PIXELS = 16,
  parameter int unsigned CONFIRM_FRAMES     = 3,
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   enable,
  input  logic                   playerDrawingRequest,
  input  logic                   flagDrawingRequest,
  input  logic [3:0]             flagHitEdgeCode,
  output logic                   levelComplete,
  output logic                   goalReached,
  output logic [COUNT_WIDTH-1:0] overlapPixelCount,
  output logic [3:0]             hitEdgeLatched,
  output logic [3:0]             frameHitCount
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CONFIRMING,
    DONE
  } state_t;

  localparam logic [3:0]             CONFIRM_VAL = 4'(CONFIRM_FRAMES);
  localparam logic [COUNT_WIDTH-1:0] MIN_VAL     = COUNT_WIDTH'(MIN_OVERLAP_PIXELS);

  state_t                 state, state_n;
  logic [COUNT_WIDTH-1:0] acc_cnt, acc_cnt_n;
  logic [3:0]             acc_edge, acc_edge_n;
  logic [COUNT_WIDTH-1:0] overlap_cnt_n;
  logic [3:0]             hit_edge_n;
  logic [3:0]             frame_hits_n;
  logic                   level_complete_n;

  logic                   overlap;
  logic                   frame_hit;
  logic [COUNT_WIDTH-1:0] acc_cnt_inc;
  logic [COUNT_WIDTH-1:0] acc_cnt_start;
  logic [3:0]             acc_edge_start;
  logic [3:0]             frame_hits_inc;

  assign overlap        = playerDrawingRequest & flagDrawingRequest;
  // Judged on the count before this cycle's pixel: the SOF pixel opens the new frame.
  assign frame_hit      = (acc_cnt >= MIN_VAL);
  assign acc_cnt_inc    = (acc_cnt == '1) ? acc_cnt : acc_cnt + 1'b1;
  assign acc_cnt_start  = {{(COUNT_WIDTH-1){1'b0}}, overlap};
  assign acc_edge_start = overlap ? flagHitEdgeCode : '0;
  assign frame_hits_inc = frameHitCount + 4'd1;

  always_comb begin
    state_n       = state;
    acc_cnt_n     = acc_cnt;
    acc_edge_n    = acc_edge;
    overlap_cnt_n = overlapPixelCount;
    hit_edge_n    = hitEdgeLatched;
    frame_hits_n  = frameHitCount;

    if (!enable) begin
      state_n       = IDLE;
      acc_cnt_n     = '0;
      acc_edge_n    = '0;
      overlap_cnt_n = '0;
      hit_edge_n    = '0;
      frame_hits_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          acc_cnt_n  = '0;
          acc_edge_n = '0;
          if (startOfFrame) begin
            state_n    = ARMED;
            acc_cnt_n  = acc_cnt_start;
            acc_edge_n = acc_edge_start;
          end
        end

        ARMED, CONFIRMING: begin
          if (startOfFrame) begin
            overlap_cnt_n = acc_cnt;
            hit_edge_n    = acc_edge;
            acc_cnt_n     = acc_cnt_start;
            acc_edge_n    = acc_edge_start;
            if (frame_hit) begin
              // From ARMED the streak is restarting, so the next count is 1
              // regardless of any stale value.
              frame_hits_n = (state == ARMED) ? 4'd1 : frame_hits_inc;
              if (frame_hits_n == CONFIRM_VAL) begin
                state_n = DONE;
              end else begin
                state_n = CONFIRMING;
              end
            end else begin
              frame_hits_n = '0;
              state_n      = ARMED;
            end
          end else if (overlap) begin
            acc_cnt_n  = acc_cnt_inc;
            acc_edge_n = acc_edge | flagHitEdgeCode;
          end
        end

        DONE: begin
          state_n = DONE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end

    level_complete_n = (state_n == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state             <= IDLE;
      acc_cnt           <= '0;
      acc_edge          <= '0;
      overlapPixelCount <= '0;
      hitEdgeLatched    <= '0;
      frameHitCount     <= '0;
      goalReached       <= 1'b0;
      levelComplete     <= 1'b0;
    end else begin
      state             <= state_n;
      acc_cnt           <= acc_cnt_n;
      acc_edge          <= acc_edge_n;
      overlapPixelCount <= overlap_cnt_n;
      hitEdgeLatched    <= hit_edge_n;
      frameHitCount     <= frame_hits_n;
      goalReached       <= (state_n == DONE);
      levelComplete     <= level_complete_n;
    end
  end

endmodule

// File: tb/tb_finish_flag_goal_detector.sv
module tb_finish_flag_goal_detector;

  localparam int MIN_PIX = 16;
  localparam int CONF    = 3;
  localparam int CW      = 16;
  localparam int SAT     = 65535;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic          enable = 1'b0;
  logic          playerDrawingRequest = 1'b0;
  logic          flagDrawingRequest = 1'b0;
  logic [3:0]    flagHitEdgeCode = 4'd0;
  logic          levelComplete;
  logic          goalReached;
  logic [CW-1:0] overlapPixelCount;
  logic [3:0]    hitEdgeLatched;
  logic [3:0]    frameHitCount;

  finish_flag_goal_detector #(
    .MIN_OVERLAP_PIXELS(MIN_PIX),
    .CONFIRM_FRAMES(CONF),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .enable(enable),
    .playerDrawingRequest(playerDrawingRequest),
    .flagDrawingRequest(flagDrawingRequest),
    .flagHitEdgeCode(flagHitEdgeCode),
    .levelComplete(levelComplete),
    .goalReached(goalReached),
    .overlapPixelCount(overlapPixelCount),
    .hitEdgeLatched(hitEdgeLatched),
    .frameHitCount(frameHitCount)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame-level view (armed/done flags, running streak,
  // unbounded pixel tally clamped only when reported).
  bit       m_armed, m_done;
  int       m_acc;
  bit [3:0] m_edge;
  bit       e_lc, e_goal;
  int       e_opc, e_fhc;
  bit [3:0] e_hel;
  bit       ov;
  assign ov = playerDrawingRequest & flagDrawingRequest;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_armed <= 0; m_done <= 0; m_acc <= 0; m_edge <= 0;
      e_lc <= 0; e_goal <= 0; e_opc <= 0; e_fhc <= 0; e_hel <= 0;
    end else begin
      e_lc <= 0;
      if (!enable) begin
        m_armed <= 0; m_done <= 0; m_acc <= 0; m_edge <= 0;
        e_goal <= 0; e_opc <= 0; e_fhc <= 0; e_hel <= 0;
      end else if (m_done) begin
        // goal held; everything frozen
      end else if (!m_armed) begin
        if (startOfFrame) begin
          m_armed <= 1;
          m_acc   <= ov ? 1 : 0;
          m_edge  <= ov ? flagHitEdgeCode : 4'd0;
        end
      end else if (startOfFrame) begin
        e_opc <= (m_acc > SAT) ? SAT : m_acc;
        e_hel <= m_edge;
        if (m_acc >= MIN_PIX) begin
          e_fhc <= e_fhc + 1;
          if (e_fhc + 1 == CONF) begin
            m_done <= 1; e_goal <= 1; e_lc <= 1;
          end
        end else begin
          e_fhc <= 0;
        end
        m_acc  <= ov ? 1 : 0;
        m_edge <= ov ? flagHitEdgeCode : 4'd0;
      end else if (ov) begin
        m_acc  <= m_acc + 1;
        m_edge <= m_edge | flagHitEdgeCode;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_levelComplete", {31'd0, levelComplete}, {31'd0, e_lc});
      chk("model_goalReached", {31'd0, goalReached}, {31'd0, e_goal});
      chk("model_overlapPixelCount", {16'd0, overlapPixelCount}, e_opc);
      chk("model_hitEdgeLatched", {28'd0, hitEdgeLatched}, {28'd0, e_hel});
      chk("model_frameHitCount", {28'd0, frameHitCount}, e_fhc);
    end
  end

  // Drive one pixel cycle; returns shortly after the edge that samples it.
  task automatic step(input bit sof, input bit en, input bit p, input bit f, input logic [3:0] code);
    @(negedge clk);
    startOfFrame         = sof;
    enable               = en;
    playerDrawingRequest = p;
    flagDrawingRequest   = f;
    flagHitEdgeCode      = code;
    @(posedge clk);
    #1;
  endtask

  task automatic body(input int n, input logic [3:0] code);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1, code);
    step(0, 1, 0, 0, 4'd0);
    step(0, 1, 0, 1, 4'd2);
  endtask

  task automatic sof(input bit en);
    step(1, en, 0, 0, 4'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_lc"}, {31'd0, levelComplete}, 0);
    chk({tag, "_goal"}, {31'd0, goalReached}, 0);
    chk({tag, "_opc"}, {16'd0, overlapPixelCount}, 0);
    chk({tag, "_hel"}, {28'd0, hitEdgeLatched}, 0);
    chk({tag, "_fhc"}, {28'd0, frameHitCount}, 0);
  endtask

  int streak_pix[6] = '{20, 20, 0, 20, 20, 20};
  int streak_fhc[6] = '{1, 2, 0, 1, 2, 3};

  initial begin
    // Reset, then a mid-frame reset pulse of 3 cycles
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;
    sof(1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 4'hF);
    @(negedge clk);
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset_mid_frame");
    #2 resetN = 1'b1;

    // Overlap with enable low is ignored
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 4'hF);
    sof(0);
    all_zero("disabled_overlap");

    // Nominal goal
    sof(1);
    body(20, 4'b0010);
    sof(1);
    chk("nominal_fhc1", {28'd0, frameHitCount}, 1);
    chk("nominal_opc1", {16'd0, overlapPixelCount}, 20);
    body(20, 4'b0010);
    sof(1);
    chk("nominal_fhc2", {28'd0, frameHitCount}, 2);
    chk("nominal_lc_early", {31'd0, levelComplete}, 0);
    body(20, 4'b0010);
    sof(1);
    chk("nominal_fhc3", {28'd0, frameHitCount}, 3);
    chk("nominal_lc_pulse", {31'd0, levelComplete}, 1);
    chk("nominal_goal", {31'd0, goalReached}, 1);
    chk("nominal_opc", {16'd0, overlapPixelCount}, 20);
    chk("nominal_hel", {28'd0, hitEdgeLatched}, 4'b0010);
    step(0, 1, 0, 0, 4'd0);
    chk("nominal_lc_drop", {31'd0, levelComplete}, 0);
    chk("nominal_goal_hold", {31'd0, goalReached}, 1);
    body(30, 4'b1111);
    sof(1);
    chk("done_no_repulse", {31'd0, levelComplete}, 0);
    chk("done_opc_hold", {16'd0, overlapPixelCount}, 20);
    chk("done_fhc_hold", {28'd0, frameHitCount}, 3);
    step(0, 0, 0, 0, 4'd0);
    all_zero("disable_from_done");

    // Threshold edge
    sof(1);
    body(15, 4'b0001);
    sof(1);
    chk("thresh15_opc", {16'd0, overlapPixelCount}, 15);
    chk("thresh15_fhc", {28'd0, frameHitCount}, 0);
    body(16, 4'b0001);
    sof(1);
    chk("thresh16_opc", {16'd0, overlapPixelCount}, 16);
    chk("thresh16_fhc", {28'd0, frameHitCount}, 1);
    step(0, 0, 0, 0, 4'd0);

    // Broken streak
    sof(1);
    for (int k = 0; k < 6; k++) begin
      body(streak_pix[k], 4'b0100);
      sof(1);
      chk($sformatf("streak_fhc%0d", k), {28'd0, frameHitCount}, streak_fhc[k]);
      chk($sformatf("streak_lc%0d", k), {31'd0, levelComplete}, (k == 5) ? 1 : 0);
    end
    step(0, 0, 0, 0, 4'd0);

    // Edge OR; flag-only pixel does not contribute
    sof(1);
    step(0, 1, 1, 1, 4'b1000);
    step(0, 1, 1, 1, 4'b0001);
    step(0, 1, 1, 1, 4'b1001);
    step(0, 1, 0, 1, 4'b0100);
    step(0, 1, 1, 0, 4'b0110);
    sof(1);
    chk("edge_or_hel", {28'd0, hitEdgeLatched}, 4'b1001);
    chk("edge_or_opc", {16'd0, overlapPixelCount}, 3);
    step(0, 0, 0, 0, 4'd0);

    // Abort on the completing startOfFrame
    sof(1);
    body(20, 4'b0010);
    sof(1);
    body(20, 4'b0010);
    sof(1);
    chk("abort_pre_fhc", {28'd0, frameHitCount}, 2);
    body(20, 4'b0010);
    sof(0);
    all_zero("abort");
    step(0, 1, 0, 0, 4'd0);
    chk("abort_lc_after", {31'd0, levelComplete}, 0);
    chk("abort_goal_after", {31'd0, goalReached}, 0);

    // Saturation
    sof(1);
    cmp_on = 1'b0;
    for (int i = 0; i < 70000; i++) step(0, 1, 1, 1, 4'b0011);
    cmp_on = 1'b1;
    sof(1);
    chk("sat_opc", {16'd0, overlapPixelCount}, 65535);
    chk("sat_fhc", {28'd0, frameHitCount}, 1);
    chk("sat_hel", {28'd0, hitEdgeLatched}, 4'b0011);
    step(0, 0, 0, 0, 4'd0);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/finish_flag_goal_detector.md
Name: finish_flag_goal_detector

Overview:
- Sits directly downstream of the finish-flag bitmap stage and the player bitmap stage, consuming their per-pixel drawingRequest and the flag's HitEdgeCode.
- Counts player/flag overlap pixels per video frame and ORs the touched flag edges.
- Declares the goal reached once overlap meets a pixel threshold for CONFIRM_FRAMES consecutive frames, then issues a one-cycle levelComplete pulse to the game controller.

Parameters:
- MIN_OVERLAP_PIXELS, 16: overlap pixels needed in a frame for it to count as a hit frame.
- CONFIRM_FRAMES, 3: consecutive hit frames required to reach the goal; legal range 1..15.
- COUNT_WIDTH, 16: width of the overlap pixel counter.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse marking the first pixel of a frame.
- enable  in  1  level is running; low disarms the detector.
- playerDrawingRequest  in  1  player pixel opaque; cycle-aligned with the flag inputs by upstream.
- flagDrawingRequest  in  1  flag pixel opaque.
- flagHitEdgeCode  in  4  {Left, Top, Right, Bottom} edge code of the current flag pixel.
- levelComplete  out  1  one-cycle pulse when the goal is reached.
- goalReached  out  1  level; high while in DONE.
- overlapPixelCount  out  COUNT_WIDTH  overlap pixel count of the last completed frame.
- hitEdgeLatched  out  4  OR of edge codes over overlap pixels of the last completed frame.
- frameHitCount  out  4  current consecutive hit-frame count.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; accumulators 0. Reset mid-operation aborts everything immediately, with no pulse.
- All outputs are registered. Every startOfFrame-triggered effect is visible the cycle after the clock edge that samples startOfFrame=1.
- overlap = playerDrawingRequest & flagDrawingRequest. Accumulation happens only in ARMED and CONFIRMING.
- Per overlap cycle:
  - acc_cnt increments, saturating at 2^COUNT_WIDTH-1.
  - acc_edge |= flagHitEdgeCode.
- Frame boundary, on a startOfFrame cycle in ARMED or CONFIRMING:
  - overlapPixelCount <= acc_cnt; hitEdgeLatched <= acc_edge.
  - frameHit = (acc_cnt >= MIN_OVERLAP_PIXELS), evaluated on acc_cnt before the current cycle's overlap is added.
  - Accumulators restart with the current cycle's overlap: acc_cnt = overlap ? 1 : 0, acc_edge = overlap ? code : 0. The startOfFrame pixel belongs to the new frame.
- FSM states: IDLE, ARMED, CONFIRMING, DONE.
  - IDLE: accumulators held at 0. On startOfFrame with enable=1 -> ARMED, with accumulators started as above. This prevents evaluating partial frames.
  - ARMED, on startOfFrame:
    - frameHit: frameHitCount=1; -> DONE if CONFIRM_FRAMES==1, else -> CONFIRMING.
    - no hit: stay ARMED, frameHitCount=0.
  - CONFIRMING, on startOfFrame:
    - frameHit: frameHitCount+1; -> DONE when that value equals CONFIRM_FRAMES.
    - no hit: -> ARMED, frameHitCount=0.
  - DONE: goalReached=1; accumulators frozen; overlapPixelCount and hitEdgeLatched hold their last values; frameHitCount holds CONFIRM_FRAMES.
- levelComplete is high exactly one cycle, in the cycle after the transition into DONE. There is no re-pulse while in DONE.
- enable=0 in any state -> IDLE on the next edge. This clears goalReached, frameHitCount, accumulators, overlapPixelCount and hitEdgeLatched.
  - enable=0 takes priority over a simultaneous startOfFrame, including one that would complete the goal: no pulse is issued.
- Overlap during IDLE or DONE is ignored.
- frameHitCount never exceeds CONFIRM_FRAMES.

Test Plan:
- Reset then idle: resetN low for 3 cycles mid-frame -> all outputs 0. Overlap pixels with enable=0 -> counts stay 0.
- Nominal goal: enable=1, then startOfFrame #1, followed by 3 frames each with 20 overlap pixels, each frame closed by the next startOfFrame (#2, #3, #4).
  - frameHitCount reads 1, 2, 3.
  - levelComplete is 1 for exactly one cycle after #4; goalReached stays 1.
  - overlapPixelCount=20.
- Threshold edge: a frame with 15 overlap pixels -> overlapPixelCount=15, frameHitCount=0. A frame with 16 pixels -> frameHitCount=1.
- Broken streak: frame sequence hit, hit, miss, hit, hit, hit (20/20/0/20/20/20 pixels).
  - frameHitCount reads 1, 2, 0, 1, 2, 3.
  - levelComplete pulses only after the 6th evaluation.
- Edge OR: a frame with overlap pixels carrying codes 4'b1000, 4'b0001, 4'b1001 -> hitEdgeLatched=4'b1001. A flag-only pixel with code 4'b0100 and no player pixel does not contribute.
- Abort and saturation:
  - enable dropped in the same cycle as the completing startOfFrame -> no levelComplete; next-cycle state IDLE, all counts 0.
  - 70000 overlap pixels in one frame -> overlapPixelCount=65535.
